// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for window_3x3_gen.
// frame_done exists only when WINDOW_3X3_GEN_FRAME_DONE_EN is defined.
interface window_3x3_gen_if;
  logic        input_is_valid;
  logic [23:0] pixel_in;
  logic        sof;
  logic [23:0] in1;
  logic [23:0] in2;
  logic [23:0] in3;
  logic [23:0] in4;
  logic [23:0] in5;
  logic [23:0] in6;
  logic [23:0] in7;
  logic [23:0] in8;
  logic [23:0] in9;
  logic        output_is_valid;
`ifdef WINDOW_3X3_GEN_FRAME_DONE_EN
  logic        frame_done;

  modport master (
    output input_is_valid, pixel_in, sof,
    input  in1, in2, in3, in4, in5, in6, in7, in8, in9, output_is_valid, frame_done
  );

  modport slave (
    input  input_is_valid, pixel_in, sof,
    output in1, in2, in3, in4, in5, in6, in7, in8, in9, output_is_valid, frame_done
  );
`else
  modport master (
    output input_is_valid, pixel_in, sof,
    input  in1, in2, in3, in4, in5, in6, in7, in8, in9, output_is_valid
  );

  modport slave (
    input  input_is_valid, pixel_in, sof,
    output in1, in2, in3, in4, in5, in6, in7, in8, in9, output_is_valid
  );
`endif
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator over a raster RGB stream using two line buffers.
// Optional one-cycle frame_done pulse when WINDOW_3X3_GEN_FRAME_DONE_EN is defined.
module window_3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input logic             clk,
  input logic             rst,
  window_3x3_gen_if.slave bus
);
  localparam int unsigned PIX_W = 24;
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col_c;
  logic [ROW_W-1:0] cur_row_c;
  logic [COL_W-1:0] col_nxt_c;
  logic [ROW_W-1:0] row_nxt_c;
  logic [PIX_W-1:0] top_rd_c;
  logic [PIX_W-1:0] mid_rd_c;
  logic             win_ok_c;

  logic [PIX_W-1:0] lb_top [IMG_WIDTH];
  logic [PIX_W-1:0] lb_mid [IMG_WIDTH];
  logic [PIX_W-1:0] win    [9];
  logic             valid;

  // sof forces the current beat to (0,0); everything else works off this position
  always_comb begin
    cur_col_c = col;
    cur_row_c = row;
    col_nxt_c = col;
    row_nxt_c = row;
    if (bus.sof) begin
      cur_col_c = '0;
      cur_row_c = '0;
    end
    if (bus.input_is_valid) begin
      if (cur_col_c == COL_LAST) begin
        col_nxt_c = '0;
        row_nxt_c = (cur_row_c == ROW_LAST) ? '0 : cur_row_c + ROW_W'(1);
      end else begin
        col_nxt_c = cur_col_c + COL_W'(1);
        row_nxt_c = cur_row_c;
      end
    end
    top_rd_c = lb_top[cur_col_c];
    mid_rd_c = lb_mid[cur_col_c];
    win_ok_c = bus.input_is_valid && (cur_row_c >= ROW_MIN) && (cur_col_c >= COL_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt_c;
      row <= row_nxt_c;
    end
  end

  // Line buffers are never cleared; the row>=2 gate hides stale contents
  always_ff @(posedge clk) begin
    if (!rst && bus.input_is_valid) begin
      lb_top[cur_col_c] <= mid_rd_c;
      lb_mid[cur_col_c] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (bus.input_is_valid) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= top_rd_c;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= mid_rd_c;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else begin
      valid <= win_ok_c;
    end
  end

  assign bus.in1             = win[0];
  assign bus.in2             = win[1];
  assign bus.in3             = win[2];
  assign bus.in4             = win[3];
  assign bus.in5             = win[4];
  assign bus.in6             = win[5];
  assign bus.in7             = win[6];
  assign bus.in8             = win[7];
  assign bus.in9             = win[8];
  assign bus.output_is_valid = valid;

`ifdef WINDOW_3X3_GEN_FRAME_DONE_EN
  logic frame_done;

  // Marks the window completed by the last pixel of the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= win_ok_c && (cur_row_c == ROW_LAST) && (cur_col_c == COL_LAST);
    end
  end

  assign bus.frame_done = frame_done;
`endif
endmodule
